// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// IF-stage front end. It owns the fetch PC, issues word-aligned requests to instruction memory,
// buffers in-order returns in a small FIFO and presents {instr_o, pc_o} registered to decode.
// Ports:
//   clk_i, rst_ni                  clock (rising edge), synchronous active-low reset
//   pc_en_i                        0 = hazard stall: no new request, fetch PC held
//   if_en_i                        0 = hold the decode-facing register
//   flush_i                        squash the instruction presented to decode
//   pc_src_i, branch_pc_i          taken-branch redirect and its target
//   imem_req_o, imem_addr_o        request and word-aligned fetch address
//   imem_gnt_i                     request accepted (req & gnt)
//   imem_rvalid_i, imem_rdata_i    in-order response
//   instr_o, pc_o, instr_valid_o   registered instruction, its PC and valid flag
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_en_i,
    input  logic        if_en_i,
    input  logic        flush_i,
    input  logic        pc_src_i,
    input  logic [63:0] branch_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        instr_valid_o
);

    localparam logic [31:0]     Nop     = 32'h0000_0013;
    localparam int unsigned     PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW:0]   DepthC  = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] outst_q, outst_d;
    logic [CntW-1:0] discard_q, discard_d;

    // PCs of live (non-discarded) requests still waiting for their response
    logic [63:0]     pcq_mem_q [FIFO_DEPTH];
    logic [63:0]     pcq_mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

    // Returned instructions waiting for decode
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [31:0]     fifo_instr_d [FIFO_DEPTH];
    logic [63:0]     fifo_pc_q [FIFO_DEPTH];
    logic [63:0]     fifo_pc_d [FIFO_DEPTH];
    logic [PtrW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic req, hs, drop, accept, squash, fifo_empty, bypass, pop, push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        squash     = flush_i | pc_src_i;
        fifo_empty = (fifo_cnt_q == '0);
        // Credit rule: in-flight plus buffered never exceeds the FIFO, so it cannot overflow
        req        = (state_q == StRun) & pc_en_i & ~pc_src_i &
                     (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < DepthC);
        hs         = req & imem_gnt_i;
        // Stale responses are dropped; so is any response landing with a redirect
        drop       = imem_rvalid_i & ((discard_q != '0) | pc_src_i);
        accept     = imem_rvalid_i & ~drop;
        bypass     = accept & fifo_empty & if_en_i & ~squash;
        push       = accept & ~bypass;
        pop        = ~squash & if_en_i & ~fifo_empty;

        fetch_pc_d = fetch_pc_q;
        if (pc_src_i) begin
            fetch_pc_d = branch_pc_i & ~64'd3;
        end else if (hs) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
        end

        outst_d   = outst_q + CntW'(hs) - CntW'(imem_rvalid_i);
        discard_d = discard_q;
        if (pc_src_i) begin
            // Everything still in flight after this edge is stale; discard never exceeds
            // outstanding, so a redirect while draining simply widens the window.
            discard_d = outst_d;
        end else if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CntW'(1);
        end

        state_d = (state_q == StIdle) ? StRun : ((discard_d != '0) ? StDrain : StRun);

        pcq_mem_d = pcq_mem_q;
        pcq_rd_d  = pcq_rd_q;
        pcq_wr_d  = pcq_wr_q;
        if (pc_src_i) begin
            pcq_rd_d = '0;
            pcq_wr_d = '0;
        end else begin
            if (hs) begin
                pcq_mem_d[pcq_wr_q] = fetch_pc_q;
                pcq_wr_d            = ptr_inc(pcq_wr_q);
            end
            if (accept) begin
                pcq_rd_d = ptr_inc(pcq_rd_q);
            end
        end

        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_cnt_d   = fifo_cnt_q;
        if (pc_src_i) begin
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (push) begin
                fifo_instr_d[fifo_wr_q] = imem_rdata_i;
                fifo_pc_d[fifo_wr_q]    = pcq_mem_q[pcq_rd_q];
                fifo_wr_d               = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
            fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
        end

        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (squash) begin
            instr_d = Nop;
            valid_d = 1'b0;
        end else if (if_en_i) begin
            if (!fifo_empty) begin
                instr_d = fifo_instr_q[fifo_rd_q];
                pc_d    = fifo_pc_q[fifo_rd_q];
                valid_d = 1'b1;
            end else if (bypass) begin
                instr_d = imem_rdata_i;
                pc_d    = pcq_mem_q[pcq_rd_q];
                valid_d = 1'b1;
            end else begin
                instr_d = Nop;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            instr_q    <= Nop;
            pc_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    // Storage needs no reset: the pointers and counts decide what is valid
    always_ff @(posedge clk_i) begin
        pcq_mem_q    <= pcq_mem_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = fetch_pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;

endmodule
